// File: rtl/fft_pkg.sv
// fft_pkg: shared lane count, select width, frame length and lane-index type for the FFT datapath
package fft_pkg;
   localparam int NUM_STAGES = 5;
   localparam int STAGE_W    = 3;
   localparam int FRAME_LEN  = 32;
   typedef logic [STAGE_W-1:0] lane_idx_t;
   function automatic logic lane_valid(input lane_idx_t l);
      return l < lane_idx_t'(NUM_STAGES);
   endfunction
endpackage

// File: rtl/fft_lane_reg.sv
// fft_lane_reg: one-entry valid/ready output register with an explicit load strobe
module fft_lane_reg #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [N-1:0] data_i,
   input  logic         ready_i,
   output logic [N-1:0] data_o,
   output logic         valid_o,
   output logic         can_load_o
);
   logic [N-1:0] data_q, data_d;
   logic         valid_q, valid_d;
   always_comb begin
      data_d  = load_i ? data_i : data_q;
      valid_d = load_i | (valid_q & ~ready_i);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end
   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign can_load_o = ~valid_q | ready_i;
endmodule

// File: rtl/fft_stage_demux.sv
// fft_stage_demux: steers one sample stream into five stage lanes, by whole frames or by external select
module fft_stage_demux
   import fft_pkg::*;
#(
   parameter int N     = 16,
   parameter int FRAME = FRAME_LEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  manual,
   input  logic [STAGE_W-1:0]    sel_in,
   output logic [N-1:0]          m_data1,
   output logic [N-1:0]          m_data2,
   output logic [N-1:0]          m_data3,
   output logic [N-1:0]          m_data4,
   output logic [N-1:0]          m_data5,
   output logic [NUM_STAGES-1:0] m_valid,
   input  logic [NUM_STAGES-1:0] m_ready,
   output logic [STAGE_W-1:0]    stage,
   output logic                  frame_done,
   output logic                  sel_err
);
   localparam int BW = $clog2(FRAME);
   logic [BW-1:0]         beat_q, beat_d;
   lane_idx_t             stage_q, stage_d, lane;
   logic                  frame_done_q, frame_done_d, sel_err_q, sel_err_d;
   logic                  lane_ok, accept, auto_acc;
   logic [NUM_STAGES-1:0] hit, load, can_load;
   logic [N-1:0]          data [NUM_STAGES];
   always_comb begin
      lane    = manual ? sel_in : stage_q;
      lane_ok = lane_valid(lane);
      for (int i = 0; i < NUM_STAGES; i++) hit[i] = lane == lane_idx_t'(i);
      // an out-of-range select is always accepted so the beat can be dropped
      s_ready      = lane_ok ? |(hit & can_load) : 1'b1;
      accept       = s_valid & s_ready;
      load         = accept ? hit : '0;
      auto_acc     = accept & ~manual;
      beat_d       = auto_acc ? beat_q + 1'b1 : beat_q;
      frame_done_d = auto_acc & (beat_q == BW'(FRAME - 1));
      stage_d      = frame_done_d ? (stage_q == lane_idx_t'(NUM_STAGES - 1) ? '0 : stage_q + 1'b1) : stage_q;
      sel_err_d    = accept & manual & ~lane_ok;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q       <= '0;
         stage_q      <= '0;
         frame_done_q <= 1'b0;
         sel_err_q    <= 1'b0;
      end else begin
         beat_q       <= beat_d;
         stage_q      <= stage_d;
         frame_done_q <= frame_done_d;
         sel_err_q    <= sel_err_d;
      end
   end
   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_lane
      fft_lane_reg #(.N(N)) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .load_i     (load[k]),
         .data_i     (s_data),
         .ready_i    (m_ready[k]),
         .data_o     (data[k]),
         .valid_o    (m_valid[k]),
         .can_load_o (can_load[k])
      );
   end
   assign m_data1    = data[0];
   assign m_data2    = data[1];
   assign m_data3    = data[2];
   assign m_data4    = data[3];
   assign m_data5    = data[4];
   assign stage      = stage_q;
   assign frame_done = frame_done_q;
   assign sel_err    = sel_err_q;
endmodule

// File: tb/tb_fft_stage_demux.sv
// tb_fft_stage_demux: scoreboard plus vector-table bench for the five-lane frame distributor
module tb_fft_stage_demux;
   logic        clk, rst_n, s_valid, s_ready, manual, frame_done, sel_err;
   logic [15:0] s_data, m_data1, m_data2, m_data3, m_data4, m_data5;
   logic [2:0]  sel_in, stage;
   logic [4:0]  m_valid, m_ready;
   wire  [15:0] md [5];
   assign md[0] = m_data1;
   assign md[1] = m_data2;
   assign md[2] = m_data3;
   assign md[3] = m_data4;
   assign md[4] = m_data5;

   fft_stage_demux #(.N(16), .FRAME(32)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .manual(manual), .sel_in(sel_in), .m_data1(m_data1), .m_data2(m_data2), .m_data3(m_data3),
      .m_data4(m_data4), .m_data5(m_data5), .m_valid(m_valid), .m_ready(m_ready), .stage(stage),
      .frame_done(frame_done), .sel_err(sel_err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   int          errs = 0, checks = 0, mstage = 0, mbeat = 0, dut_fd = 0;
   logic [4:0]  mv = '0;
   logic        exp_fd = 0, exp_se = 0, last_acc, sr_seen;
   logic [15:0] q [5][$];

   typedef struct {
      logic [2:0]  sel;
      logic [15:0] d;
      logic        rdy;
      logic        err;
      int          lane;
   } vec_t;
   vec_t tv[5];

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   // one clock: compare against the reference model at the falling edge, then advance the model
   task automatic cyc();
      logic [2:0] l;
      logic       er, fd, se;
      @(negedge clk);
      chk("m_valid", 32'(m_valid), 32'(mv));
      chk("stage", 32'(stage), mstage);
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("sel_err", 32'(sel_err), 32'(exp_se));
      if (frame_done) dut_fd++;
      l  = manual ? sel_in : 3'(mstage);
      er = (l < 3'd5) ? (~mv[l] | m_ready[l]) : 1'b1;
      sr_seen = s_ready;
      chk("s_ready", 32'(s_ready), 32'(er));
      for (int k = 0; k < 5; k++) if (mv[k] && m_ready[k]) begin
         if (q[k].size() == 0) begin
            errs++; checks++;
            $display("FAIL lane%0d_scoreboard: got output with no expected sample", k + 1);
         end else chk($sformatf("lane%0d_data", k + 1), 32'(md[k]), 32'(q[k].pop_front()));
         mv[k] = 1'b0;
      end
      fd = 0; se = 0;
      last_acc = s_valid & er;
      if (last_acc) begin
         if (l < 3'd5) begin
            q[l].push_back(s_data);
            mv[l] = 1'b1;
         end else se = 1;
         if (!manual) begin
            if (mbeat == 31) begin
               mbeat = 0; fd = 1;
               mstage = (mstage == 4) ? 0 : mstage + 1;
            end else mbeat++;
         end
      end
      exp_fd = fd; exp_se = se;
      @(posedge clk); #1;
   endtask

   task automatic send_auto(input int n, input logic [15:0] base);
      int i = 0, guard = 0;
      manual = 0; m_ready = 5'h1f; s_valid = 1;
      while (i < n && guard < n + 50) begin
         s_data = base + 16'(i);
         cyc();
         if (last_acc) i++;
         guard++;
      end
      if (i < n) begin
         errs++; checks++;
         $display("FAIL send_auto_timeout: got %0d beats expected %0d", i, n);
      end
      s_valid = 0;
   endtask

   initial begin
      int v, hold, stall, guard;
      tv[0] = '{3'd2, 16'hA5A5, 1'b1, 1'b0, 2};
      tv[1] = '{3'd7, 16'h1234, 1'b1, 1'b1, -1};
      tv[2] = '{3'd0, 16'h0F0F, 1'b1, 1'b0, 0};
      tv[3] = '{3'd5, 16'h5555, 1'b1, 1'b1, -1};
      tv[4] = '{3'd4, 16'hC3C3, 1'b1, 1'b0, 4};
      rst_n = 0; s_valid = 0; s_data = 0; manual = 0; sel_in = 0; m_ready = 5'h1f;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_valid", 32'(m_valid), 0);
      for (int k = 0; k < 5; k++) chk("rst_m_data", 32'(md[k]), 0);
      chk("rst_stage", 32'(stage), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_sel_err", 32'(sel_err), 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;

      // whole frames rotate through all five lanes and wrap back to lane 1
      send_auto(160, 16'd0);
      cyc();
      chk("frame_done_count", dut_fd, 5);
      chk("stage_after_160", 32'(stage), 0);

      // lane 1 backpressure for 10 cycles after sample 3
      v = 0; hold = 0; stall = 0; guard = 0;
      s_valid = 1;
      while (v < 32 && guard < 200) begin
         s_data = 16'(v);
         m_ready = (v >= 4 && hold < 10) ? 5'h1e : 5'h1f;
         cyc();
         if (m_ready[0] == 1'b0) hold++;
         if (!sr_seen) stall++;
         if (last_acc) v++;
         guard++;
      end
      s_valid = 0;
      chk("bp_all_sent", v, 32);
      chk("bp_stall_cycles", stall, 10);
      m_ready = 5'h1f;
      cyc();
      chk("bp_stage", 32'(stage), 1);

      // manual select table, counters must hold
      manual = 1; s_valid = 1;
      for (int i = 0; i < 5; i++) begin
         sel_in = tv[i].sel; s_data = tv[i].d;
         cyc();
         chk("tbl_s_ready", 32'(sr_seen), 32'(tv[i].rdy));
         chk("tbl_sel_err", 32'(sel_err), 32'(tv[i].err));
         if (tv[i].lane >= 0) begin
            chk("tbl_lane_valid", 32'(m_valid[tv[i].lane]), 1);
            chk("tbl_lane_data", 32'(md[tv[i].lane]), 32'(tv[i].d));
         end else chk("tbl_no_load", 32'(m_valid), 0);
      end
      s_valid = 0;
      cyc();
      chk("sel_err_single_pulse", 32'(sel_err), 0);
      chk("manual_stage_hold", 32'(stage), 1);

      // manual detour at beat 10 of stage 1, auto resumes at beat 10 of lane 2
      send_auto(10, 16'h2000);
      manual = 1; sel_in = 3'd4; s_valid = 1;
      for (int i = 0; i < 4; i++) begin
         s_data = 16'h4000 + 16'(i);
         cyc();
      end
      s_valid = 0;
      manual = 0; s_valid = 1; s_data = 16'h7777;
      cyc();
      s_valid = 0;
      chk("resume_lane2_valid", 32'(m_valid[1]), 1);
      chk("resume_lane2_data", 32'(m_data2), 16'h7777);
      send_auto(20, 16'h3000);
      chk("resume_stage_before_wrap", 32'(stage), 1);
      send_auto(1, 16'h3100);
      chk("resume_stage_after_wrap", 32'(stage), 2);
      send_auto(5, 16'h3200);

      // fill every lane, then reset mid-frame
      manual = 1; m_ready = 5'h00; s_valid = 1;
      for (int k = 0; k < 5; k++) begin
         sel_in = 3'(k); s_data = 16'h100 + 16'(k);
         cyc();
      end
      s_valid = 0;
      chk("full_before_reset", 32'(m_valid), 32'h1f);
      #2 rst_n = 0;
      #1;
      chk("async_rst_m_valid", 32'(m_valid), 0);
      for (int k = 0; k < 5; k++) chk("async_rst_m_data", 32'(md[k]), 0);
      chk("async_rst_stage", 32'(stage), 0);
      mv = '0; mstage = 0; mbeat = 0; exp_fd = 0; exp_se = 0;
      for (int k = 0; k < 5; k++) q[k].delete();
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      manual = 0; s_valid = 1; s_data = 16'hBEEF;
      cyc();
      s_valid = 0;
      chk("post_rst_lane1_valid", 32'(m_valid), 1);
      chk("post_rst_lane1_data", 32'(m_data1), 16'hBEEF);
      m_ready = 5'h1f;
      guard = 0;
      while (mv != 0 && guard < 5) begin
         cyc();
         guard++;
      end
      cyc();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
